// File: rtl/sr_readback.sv
// Deserializes the chip shift-register readback and compares it bit-by-bit against the written word.
// Optional build macro SR_READBACK_FIRST_ERR_EN enables first-mismatch index tracking.
module sr_readback #(
  parameter int WIDTH   = 170,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             dout_sr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err,
  output logic             busy,
  output logic             done,
  output logic             match,
  output logic             timeout
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic [IDLE_W-1:0]  idle_q, idle_d;
  logic               busy_q, done_q, match_q, match_d, timeout_q, timeout_d;
  logic [CNT_W-1:0]   bit_idx;
  logic               mismatch;
`ifdef SR_READBACK_FIRST_ERR_EN
  logic [CNT_W-1:0]   ferr_q, ferr_d;
`endif

  always_comb begin
    state_d   = state_q;
    dout_d    = dout_q;
    count_d   = count_q;
    err_d     = err_q;
    idle_d    = idle_q;
    match_d   = match_q;
    timeout_d = timeout_q;
`ifdef SR_READBACK_FIRST_ERR_EN
    ferr_d    = ferr_q;
`endif
    // Bits arrive MSB first, so send index n lines up with din[WIDTH-1-n].
    bit_idx  = CNT_W'(WIDTH - 1) - count_q;
    mismatch = dout_sr ^ din[bit_idx];

    if (start) begin
      // A start in any state restarts cleanly; a coincident bit is dropped.
      state_d   = S_CAPTURE;
      dout_d    = '0;
      count_d   = '0;
      err_d     = '0;
      idle_d    = '0;
      match_d   = 1'b0;
      timeout_d = 1'b0;
`ifdef SR_READBACK_FIRST_ERR_EN
      ferr_d    = '1;
`endif
    end else begin
      case (state_q)
        S_CAPTURE: begin
          if (bit_valid) begin
            dout_d  = {dout_q[WIDTH-2:0], dout_sr};
            count_d = count_q + 1'b1;
            idle_d  = '0;
            if (mismatch) begin
              err_d = err_q + 1'b1;
`ifdef SR_READBACK_FIRST_ERR_EN
              if (err_q == '0) ferr_d = count_q;
`endif
            end
            if (count_d == CNT_W'(WIDTH)) state_d = S_DONE;
          end else begin
            idle_d = idle_q + 1'b1;
            if (idle_d == IDLE_W'(TIMEOUT)) begin
              state_d   = S_DONE;
              timeout_d = 1'b1;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    // Verdict is latched on the way into DONE so it is visible alongside the done pulse.
    if (state_d == S_DONE)
      match_d = (count_d == CNT_W'(WIDTH)) && (err_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      dout_q    <= '0;
      count_q   <= '0;
      err_q     <= '0;
      idle_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      match_q   <= 1'b0;
      timeout_q <= 1'b0;
`ifdef SR_READBACK_FIRST_ERR_EN
      ferr_q    <= '1;
`endif
    end else begin
      state_q   <= state_d;
      dout_q    <= dout_d;
      count_q   <= count_d;
      err_q     <= err_d;
      idle_q    <= idle_d;
      busy_q    <= (state_d == S_CAPTURE);
      done_q    <= (state_d == S_DONE);
      match_q   <= match_d;
      timeout_q <= timeout_d;
`ifdef SR_READBACK_FIRST_ERR_EN
      ferr_q    <= ferr_d;
`endif
    end
  end

  assign dout    = dout_q;
  assign count   = count_q;
  assign err_cnt = err_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign match   = match_q;
  assign timeout = timeout_q;
`ifdef SR_READBACK_FIRST_ERR_EN
  assign first_err = ferr_q;
`else
  assign first_err = '1;
`endif

endmodule

// File: doc/sr_readback.md
# sr_readback

Serial readback checker for the TMIIa configuration shift register. Sits directly downstream of `SR_Control`. Each time `SR_Control` shifts a word into the chip, the chip's shift-register serial output is fed into this block, which:
- deserializes it back to a `WIDTH`-bit word;
- compares it bit-by-bit against the word that was written;
- reports the captured word, mismatch count and pass/fail to the test controller.

## Interface
Parameters:
- `WIDTH`, 170, shift-register length in bits; identical to `SR_Control`.
- `CNT_W`, 8, width of the bit and error counters; must satisfy 2^CNT_W > WIDTH.
- `TIMEOUT`, 1024, maximum idle cycles between accepted bits before the capture aborts.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that arms a capture; driven by the same pulse as `SR_Control.start`.
- `bit_valid`  in  1  `dout_sr` holds a valid bit this cycle.
- `dout_sr`  in  1  serial bit from the chip shift-register output, MSB first.
- `din`  in  WIDTH  expected word; must be held stable from `start` until `done`.
- `dout`  out  WIDTH  captured word.
- `count`  out  CNT_W  bits accepted in the current or last capture.
- `err_cnt`  out  CNT_W  mismatching bits in the current or last capture.
- `first_err`  out  CNT_W  index (in send order) of the first mismatching bit.
- `busy`  out  1  capture in progress.
- `done`  out  1  one-cycle pulse when a capture ends.
- `match`  out  1  last capture completed with zero errors.
- `timeout`  out  1  last capture aborted on timeout.

## Operation
- FSM states: IDLE, CAPTURE, DONE.
- IDLE:
  - `start` -> CAPTURE.
  - Clears `dout`, `count`, `err_cnt`, `match`, `timeout`, the idle counter; sets `first_err` = all-ones.
  - `bit_valid` is ignored.
- CAPTURE, on `bit_valid`:
  - `dout <= {dout[WIDTH-2:0], dout_sr}`.
  - If `dout_sr != din[WIDTH-1-count]`: `err_cnt` increments; if this is the first error, `first_err <= count`.
  - `count` increments and the idle counter clears.
- CAPTURE, without `bit_valid`: the idle counter increments.
- CAPTURE -> DONE when:
  - the WIDTH-th bit is accepted, or
  - the idle counter reaches `TIMEOUT`; in that case `timeout <= 1`.
- DONE (one cycle):
  - `done = 1`.
  - `match = (count == WIDTH) && (err_cnt == 0)`.
  - Then -> IDLE.
- Results (`dout`, `count`, `err_cnt`, `first_err`, `match`, `timeout`) hold until the next `start`.

## Timing
- Reset values:
  - `dout`, `count`, `err_cnt`, `busy`, `done`, `match`, `timeout` = 0.
  - `first_err` = all-ones.
  - FSM = IDLE.
- `start` sampled in cycle N -> `busy` = 1 and counters cleared in cycle N+1; bits are accepted from cycle N+1.
- Last bit accepted in cycle M -> `done` = 1, `busy` = 0, and `match` valid in cycle M+1. `done` is high for exactly one cycle.
- Timeout: `TIMEOUT` consecutive cycles without `bit_valid` in CAPTURE -> `done` in the following cycle.
- `start` and `bit_valid` in the same CAPTURE cycle: `start` wins, the bit is dropped, and the capture restarts with count 0.
- `start` while in DONE: accepted; the next cycle is CAPTURE.
- `rst` mid-capture: all outputs return to their reset values the next cycle; no `done` pulse.
- `bit_valid` is never accepted after `count == WIDTH`.

## Configuration
- `SR_READBACK_FIRST_ERR_EN`
  - Defined: first-mismatch index tracking is built, and `first_err` behaves as described above.
  - Undefined: the tracking register is omitted, and `first_err` is constant all-ones.
  - All other behaviour is identical in both builds.

## Test plan
- `din` = 170'b1011; feed the same 170 bits MSB first with `bit_valid` every cycle -> `done` one cycle after the 170th bit; `match` = 1, `err_cnt` = 0, `count` = 170, `dout` = 170'b1011.
- Same stimulus with send-order bit 3 inverted -> `match` = 0, `err_cnt` = 1, `first_err` = 3 (all-ones if the macro is off); `dout` differs from `din` only in bit 166.
- `din` = all ones, `dout_sr` held at 0 for 170 bits -> `err_cnt` = 170, `first_err` = 0, `match` = 0.
- `TIMEOUT` = 16: send 10 bits, then stop -> `done` 17 cycles after the last bit; `timeout` = 1, `count` = 10, `match` = 0.
- `bit_valid` every 4th cycle with a correct pattern -> same result as the first scenario; `busy` high throughout the capture.
- Two boundary cases:
  - `start` with `bit_valid` after 50 bits -> `count` = 0 next cycle, then a full correct 170-bit run gives `match` = 1.
  - `rst` after 80 bits -> reset values with no `done` pulse.
